// File: rtl/tlb_op_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : tlb_op_unit_pkg
// Brief    : Shared widths, op encodings and sequencer states for the TLB op unit
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tlb_op_unit_pkg;

  localparam int TLBNUM  = 8;
  localparam int IDX_WD  = 3;

  localparam int VPN2_WD = 19;
  localparam int ASID_WD = 8;
  localparam int PFN_WD  = 20;
  localparam int C_WD    = 3;
  localparam int MASK_WD = 16;

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWI = 2'd2;
  localparam logic [1:0] OP_TLBWR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tlb_random_reg.sv
//------------------------------------------------------------------------------
// Module   : tlb_random_reg
// Brief    : CP0 Random register, free-running down-counter bounded by Wired
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tlb_random_reg
  import tlb_op_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wired_we,
  input  logic [IDX_WD-1:0] wired,
  output logic [IDX_WD-1:0] random
);

  localparam logic [IDX_WD-1:0] c_rand_max = IDX_WD'(TLBNUM - 1);

  logic [IDX_WD-1:0] r_random;
  logic              w_wired_oob;
  logic              w_reload;

  // An out-of-range Wired can only exist when TLBNUM is not a power of two.
  generate
    if (TLBNUM == (1 << IDX_WD)) begin : g_pow2
      assign w_wired_oob = 1'b0;
    end else begin : g_npow2
      assign w_wired_oob = (wired > c_rand_max);
    end
  endgenerate

  assign w_reload = wired_we | (r_random == wired) | w_wired_oob | (r_random == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_random <= c_rand_max;
    end else if (w_reload) begin
      r_random <= c_rand_max;
    end else begin
      r_random <= r_random - 1'b1;
    end
  end

  assign random = r_random;

endmodule

`default_nettype wire

// File: rtl/tlb_op_unit.sv
//------------------------------------------------------------------------------
// Module   : tlb_op_unit
// Brief    : Fixed-latency sequencer for TLBP/TLBR/TLBWI/TLBWR between CP0 and TLB
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tlb_op_unit
  import tlb_op_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [1:0]         op_type,
  output logic               op_ready,
  input  logic               op_flush,
  output logic               op_done,
  input  logic [VPN2_WD-1:0] cp0_vpn2,
  input  logic [ASID_WD-1:0] cp0_asid,
  input  logic [PFN_WD-1:0]  cp0_pfn0,
  input  logic [PFN_WD-1:0]  cp0_pfn1,
  input  logic [C_WD-1:0]    cp0_c0,
  input  logic [C_WD-1:0]    cp0_c1,
  input  logic               cp0_d0,
  input  logic               cp0_d1,
  input  logic               cp0_v0,
  input  logic               cp0_v1,
  input  logic               cp0_g0,
  input  logic               cp0_g1,
  input  logic [MASK_WD-1:0] cp0_mask,
  input  logic [IDX_WD-1:0]  cp0_index,
  input  logic [IDX_WD-1:0]  cp0_wired,
  input  logic               wired_we,
  output logic [IDX_WD-1:0]  random,
  output logic [VPN2_WD-1:0] s_vpn2,
  output logic               s_odd_page,
  output logic [ASID_WD-1:0] s_asid,
  input  logic               s_found,
  input  logic [IDX_WD-1:0]  s_index,
  output logic [IDX_WD-1:0]  r_index,
  input  logic [VPN2_WD-1:0] r_vpn2,
  input  logic [ASID_WD-1:0] r_asid,
  input  logic               r_g,
  input  logic [PFN_WD-1:0]  r_pfn0,
  input  logic [C_WD-1:0]    r_c0,
  input  logic               r_d0,
  input  logic               r_v0,
  input  logic [PFN_WD-1:0]  r_pfn1,
  input  logic [C_WD-1:0]    r_c1,
  input  logic               r_d1,
  input  logic               r_v1,
  input  logic [MASK_WD-1:0] r_mask,
  output logic               we,
  output logic [IDX_WD-1:0]  w_index,
  output logic [VPN2_WD-1:0] w_vpn2,
  output logic [ASID_WD-1:0] w_asid,
  output logic               w_g,
  output logic [PFN_WD-1:0]  w_pfn0,
  output logic [C_WD-1:0]    w_c0,
  output logic               w_d0,
  output logic               w_v0,
  output logic [PFN_WD-1:0]  w_pfn1,
  output logic [C_WD-1:0]    w_c1,
  output logic               w_d1,
  output logic               w_v1,
  output logic [MASK_WD-1:0] w_mask,
  output logic               idx_we,
  output logic               idx_p,
  output logic [IDX_WD-1:0]  idx_val,
  output logic               entry_we,
  output logic [VPN2_WD-1:0] e_vpn2,
  output logic [ASID_WD-1:0] e_asid,
  output logic [PFN_WD-1:0]  e_pfn0,
  output logic [C_WD-1:0]    e_c0,
  output logic               e_d0,
  output logic               e_v0,
  output logic               e_g0,
  output logic [PFN_WD-1:0]  e_pfn1,
  output logic [C_WD-1:0]    e_c1,
  output logic               e_d1,
  output logic               e_v1,
  output logic               e_g1,
  output logic [MASK_WD-1:0] e_mask
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;

  logic [1:0]         r_op_type;
  logic [VPN2_WD-1:0] r_op_vpn2;
  logic [ASID_WD-1:0] r_op_asid;
  logic [PFN_WD-1:0]  r_op_pfn0;
  logic [PFN_WD-1:0]  r_op_pfn1;
  logic [C_WD-1:0]    r_op_c0;
  logic [C_WD-1:0]    r_op_c1;
  logic               r_op_d0;
  logic               r_op_d1;
  logic               r_op_v0;
  logic               r_op_v1;
  logic               r_op_g0;
  logic               r_op_g1;
  logic [MASK_WD-1:0] r_op_mask;
  logic [IDX_WD-1:0]  r_op_index;
  logic               r_found;
  logic [IDX_WD-1:0]  r_found_idx;

  tlb_random_reg u_random (
    .clk      (clk),
    .reset    (reset),
    .wired_we (wired_we),
    .wired    (cp0_wired),
    .random   (random)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Reset is folded into the strobes so a mid-op reset never reaches the TLB or CP0.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    op_ready     = 1'b0;
    op_done      = 1'b0;
    we           = 1'b0;
    idx_we       = 1'b0;
    entry_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        op_ready = 1'b1;
        w_accept = op_valid & ~op_flush & ~reset;
        if (w_accept) begin
          case (op_type)
            OP_TLBP: w_state_next = ST_PROBE;
            OP_TLBR: w_state_next = ST_READ;
            default: w_state_next = ST_WRITE;
          endcase
        end
      end
      ST_PROBE, ST_READ: begin
        w_state_next = op_flush ? ST_IDLE : ST_DONE;
      end
      ST_WRITE: begin
        we           = ~op_flush & ~reset;
        w_state_next = op_flush ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        op_done      = ~reset;
        idx_we       = ~reset & (r_op_type == OP_TLBP);
        entry_we     = ~reset & (r_op_type == OP_TLBR);
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_type  <= OP_TLBP;
      r_op_vpn2  <= '0;
      r_op_asid  <= '0;
      r_op_pfn0  <= '0;
      r_op_pfn1  <= '0;
      r_op_c0    <= '0;
      r_op_c1    <= '0;
      r_op_d0    <= 1'b0;
      r_op_d1    <= 1'b0;
      r_op_v0    <= 1'b0;
      r_op_v1    <= 1'b0;
      r_op_g0    <= 1'b0;
      r_op_g1    <= 1'b0;
      r_op_mask  <= '0;
      r_op_index <= '0;
    end else if (w_accept) begin
      r_op_type  <= op_type;
      r_op_vpn2  <= cp0_vpn2;
      r_op_asid  <= cp0_asid;
      r_op_pfn0  <= cp0_pfn0;
      r_op_pfn1  <= cp0_pfn1;
      r_op_c0    <= cp0_c0;
      r_op_c1    <= cp0_c1;
      r_op_d0    <= cp0_d0;
      r_op_d1    <= cp0_d1;
      r_op_v0    <= cp0_v0;
      r_op_v1    <= cp0_v1;
      r_op_g0    <= cp0_g0;
      r_op_g1    <= cp0_g1;
      r_op_mask  <= cp0_mask;
      r_op_index <= (op_type == OP_TLBWR) ? random : cp0_index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_found     <= 1'b0;
      r_found_idx <= '0;
    end else if (r_state == ST_PROBE) begin
      r_found     <= s_found;
      r_found_idx <= s_index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_vpn2 <= '0;
      e_asid <= '0;
      e_pfn0 <= '0;
      e_c0   <= '0;
      e_d0   <= 1'b0;
      e_v0   <= 1'b0;
      e_g0   <= 1'b0;
      e_pfn1 <= '0;
      e_c1   <= '0;
      e_d1   <= 1'b0;
      e_v1   <= 1'b0;
      e_g1   <= 1'b0;
      e_mask <= '0;
    end else if (r_state == ST_READ) begin
      e_vpn2 <= r_vpn2;
      e_asid <= r_asid;
      e_pfn0 <= r_pfn0;
      e_c0   <= r_c0;
      e_d0   <= r_d0;
      e_v0   <= r_v0;
      e_g0   <= r_g;
      e_pfn1 <= r_pfn1;
      e_c1   <= r_c1;
      e_d1   <= r_d1;
      e_v1   <= r_v1;
      e_g1   <= r_g;
      e_mask <= r_mask;
    end
  end

  assign idx_p      = idx_we & ~r_found;
  assign idx_val    = (idx_we & r_found) ? r_found_idx : '0;

  assign s_vpn2     = r_op_vpn2;
  assign s_asid     = r_op_asid;
  assign s_odd_page = 1'b0;
  assign r_index    = r_op_index;

  assign w_index    = r_op_index;
  assign w_vpn2     = r_op_vpn2;
  assign w_asid     = r_op_asid;
  assign w_g        = r_op_g0 & r_op_g1;
  assign w_pfn0     = r_op_pfn0;
  assign w_c0       = r_op_c0;
  assign w_d0       = r_op_d0;
  assign w_v0       = r_op_v0;
  assign w_pfn1     = r_op_pfn1;
  assign w_c1       = r_op_c1;
  assign w_d1       = r_op_d1;
  assign w_v1       = r_op_v1;
  assign w_mask     = r_op_mask;

endmodule

`default_nettype wire

// File: tb/tb_tlb_op_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_tlb_op_unit
// Brief    : Directed self-checking bench for tlb_op_unit with stubbed TLB ports
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tlb_op_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready, op_flush, op_done;
  logic [1:0]  op_type;
  logic [18:0] cp0_vpn2;
  logic [7:0]  cp0_asid;
  logic [19:0] cp0_pfn0, cp0_pfn1;
  logic [2:0]  cp0_c0, cp0_c1;
  logic        cp0_d0, cp0_d1, cp0_v0, cp0_v1, cp0_g0, cp0_g1;
  logic [15:0] cp0_mask;
  logic [2:0]  cp0_index, cp0_wired, random;
  logic        wired_we;
  logic [18:0] s_vpn2;
  logic        s_odd_page, s_found;
  logic [7:0]  s_asid;
  logic [2:0]  s_index, r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g, r_d0, r_v0, r_d1, r_v1;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic [15:0] r_mask;
  logic        we;
  logic [2:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g, w_d0, w_v0, w_d1, w_v1;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic [15:0] w_mask;
  logic        idx_we, idx_p, entry_we;
  logic [2:0]  idx_val;
  logic [18:0] e_vpn2;
  logic [7:0]  e_asid;
  logic [19:0] e_pfn0, e_pfn1;
  logic [2:0]  e_c0, e_c1;
  logic        e_d0, e_v0, e_g0, e_d1, e_v1, e_g1;
  logic [15:0] e_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tlb_op_unit dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
    .op_flush(op_flush), .op_done(op_done), .cp0_vpn2(cp0_vpn2), .cp0_asid(cp0_asid),
    .cp0_pfn0(cp0_pfn0), .cp0_pfn1(cp0_pfn1), .cp0_c0(cp0_c0), .cp0_c1(cp0_c1),
    .cp0_d0(cp0_d0), .cp0_d1(cp0_d1), .cp0_v0(cp0_v0), .cp0_v1(cp0_v1),
    .cp0_g0(cp0_g0), .cp0_g1(cp0_g1), .cp0_mask(cp0_mask), .cp0_index(cp0_index),
    .cp0_wired(cp0_wired), .wired_we(wired_we), .random(random),
    .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g), .r_pfn0(r_pfn0), .r_c0(r_c0),
    .r_d0(r_d0), .r_v0(r_v0), .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1), .r_mask(r_mask),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g), .w_pfn0(w_pfn0),
    .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0), .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .w_mask(w_mask), .idx_we(idx_we), .idx_p(idx_p), .idx_val(idx_val), .entry_we(entry_we),
    .e_vpn2(e_vpn2), .e_asid(e_asid), .e_pfn0(e_pfn0), .e_c0(e_c0), .e_d0(e_d0), .e_v0(e_v0),
    .e_g0(e_g0), .e_pfn1(e_pfn1), .e_c1(e_c1), .e_d1(e_d1), .e_v1(e_v1), .e_g1(e_g1), .e_mask(e_mask)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cp0();
    cp0_vpn2  = 19'($urandom);
    cp0_asid  = 8'($urandom);
    cp0_index = 3'($urandom);
    cp0_g0    = 1'b0;
    cp0_g1    = 1'b0;
    op_type   = 2'($urandom);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  idx;
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g0, g1;
    logic        sf;
    logic [2:0]  sidx;
    logic        rg;
    logic [19:0] rpfn0;
    logic [15:0] rmask;
    logic        x_wg;
    logic        x_ip;
    logic [2:0]  x_ival;
  } vec_t;

  vec_t vecs[6];

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_type = 2'd0; op_flush = 1'b0;
    cp0_vpn2 = '0; cp0_asid = '0; cp0_pfn0 = '0; cp0_pfn1 = '0; cp0_c0 = '0; cp0_c1 = '0;
    cp0_d0 = 0; cp0_d1 = 0; cp0_v0 = 0; cp0_v1 = 0; cp0_g0 = 0; cp0_g1 = 0;
    cp0_mask = '0; cp0_index = '0; cp0_wired = 3'd2; wired_we = 1'b0;
    s_found = 0; s_index = '0; r_vpn2 = '0; r_asid = '0; r_g = 0; r_pfn0 = '0; r_c0 = '0;
    r_d0 = 0; r_v0 = 0; r_pfn1 = '0; r_c1 = '0; r_d1 = 0; r_v1 = 0; r_mask = '0;

    //        op     idx   vpn2       asid   g0 g1 sf sidx rg rpfn0     rmask     wg ip ival
    vecs[0] = '{2'd2, 3'd5, 19'h12345, 8'h3A, 1, 1, 0, 3'd0, 0, 20'h0,     16'h0,    1, 0, 3'd0};
    vecs[1] = '{2'd2, 3'd2, 19'h00F0F, 8'h11, 1, 0, 0, 3'd0, 0, 20'h0,     16'h0,    0, 0, 3'd0};
    vecs[2] = '{2'd0, 3'd0, 19'h12345, 8'h3A, 0, 0, 1, 3'd5, 0, 20'h0,     16'h0,    0, 0, 3'd5};
    vecs[3] = '{2'd0, 3'd4, 19'h7FFFF, 8'hFF, 0, 0, 0, 3'd6, 0, 20'h0,     16'h0,    0, 1, 3'd0};
    vecs[4] = '{2'd1, 3'd3, 19'h00000, 8'h00, 0, 0, 0, 3'd0, 1, 20'hABCDE, 16'h0003, 0, 0, 3'd0};
    vecs[5] = '{2'd1, 3'd7, 19'h00001, 8'h01, 0, 0, 0, 3'd0, 0, 20'h00042, 16'hFFFF, 0, 0, 3'd0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_random", random, 7);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_strobes", {we, idx_we, entry_we, op_done, idx_p}, 0);
    chk("rst_fields", {idx_val, w_index, r_index}, 0);
    chk("rst_s_vpn2", s_vpn2, 0);
    chk("rst_e_pfn0", e_pfn0, 0);

    // Random countdown with Wired=2
    begin
      logic [2:0] seq[7];
      seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd7, 3'd6};
      for (int i = 0; i < 7; i++) begin
        step();
        chk($sformatf("random_seq%0d", i), random, seq[i]);
      end
    end
    wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    chk("random_wired_we", random, 7);
    step(); step(); step();
    chk("random_before_wr", random, 4);

    // TLBWR picks up the current Random
    op_valid = 1'b1; op_type = 2'd3; cp0_index = 3'd1; cp0_vpn2 = 19'h0ABCD;
    cp0_g0 = 1; cp0_g1 = 1;
    chk("wr_ready_T", op_ready, 1);
    step();
    op_valid = 1'b0; scramble_cp0();
    chk("wr_we_T1", we, 1);
    chk("wr_index_T1", w_index, 4);
    chk("wr_vpn2_T1", w_vpn2, 19'h0ABCD);
    chk("wr_random_runs", random, 3);
    chk("wr_ready_T1", op_ready, 0);
    step();
    chk("wr_done_T2", {op_done, we}, 2'b10);
    step();
    chk("wr_ready_T3", {op_ready, op_done}, 2'b10);

    // Table-driven single ops
    for (int i = 0; i < 6; i++) begin
      op_valid = 1'b1; op_type = vecs[i].op; cp0_index = vecs[i].idx;
      cp0_vpn2 = vecs[i].vpn2; cp0_asid = vecs[i].asid;
      cp0_g0 = vecs[i].g0; cp0_g1 = vecs[i].g1;
      s_found = vecs[i].sf; s_index = vecs[i].sidx;
      r_g = vecs[i].rg; r_pfn0 = vecs[i].rpfn0; r_mask = vecs[i].rmask;
      chk($sformatf("v%0d_ready_T", i), op_ready, 1);
      step();
      op_valid = 1'b0; scramble_cp0();
      chk($sformatf("v%0d_we_T1", i), we, (vecs[i].op == 2'd2));
      chk($sformatf("v%0d_done_T1", i), op_done, 0);
      if (vecs[i].op == 2'd2) begin
        chk($sformatf("v%0d_w_index", i), w_index, vecs[i].idx);
        chk($sformatf("v%0d_w_g", i), w_g, vecs[i].x_wg);
        chk($sformatf("v%0d_w_asid", i), w_asid, vecs[i].asid);
      end
      if (vecs[i].op == 2'd0)
        chk($sformatf("v%0d_s_vpn2", i), {s_asid, s_vpn2, s_odd_page}, {vecs[i].asid, vecs[i].vpn2, 1'b0});
      if (vecs[i].op == 2'd1)
        chk($sformatf("v%0d_r_index", i), r_index, vecs[i].idx);
      step();
      s_found = ~vecs[i].sf; s_index = 3'($urandom); r_g = ~vecs[i].rg; r_pfn0 = 20'($urandom); r_mask = 16'($urandom);
      chk($sformatf("v%0d_done_T2", i), {op_done, we}, 2'b10);
      chk($sformatf("v%0d_idx_we", i), idx_we, (vecs[i].op == 2'd0));
      chk($sformatf("v%0d_entry_we", i), entry_we, (vecs[i].op == 2'd1));
      if (vecs[i].op == 2'd0) begin
        chk($sformatf("v%0d_idx_p", i), idx_p, vecs[i].x_ip);
        chk($sformatf("v%0d_idx_val", i), idx_val, vecs[i].x_ival);
      end
      if (vecs[i].op == 2'd1) begin
        chk($sformatf("v%0d_e_pfn0", i), e_pfn0, vecs[i].rpfn0);
        chk($sformatf("v%0d_e_mask", i), e_mask, vecs[i].rmask);
        chk($sformatf("v%0d_e_g", i), {e_g0, e_g1}, {vecs[i].rg, vecs[i].rg});
      end
      step();
      chk($sformatf("v%0d_idle_T3", i), {op_ready, op_done, idx_we, entry_we}, 4'b1000);
    end

    // Flush during the WRITE cycle
    op_valid = 1'b1; op_type = 2'd2; cp0_index = 3'd6; cp0_g0 = 1; cp0_g1 = 1;
    step();
    op_valid = 1'b0; op_flush = 1'b1;
    #1 chk("flush_we", we, 0);
    step();
    op_flush = 1'b0;
    chk("flush_ready", {op_ready, op_done, we}, 3'b100);
    step();
    chk("flush_no_done", op_done, 0);

    // Reset while in PROBE
    op_valid = 1'b1; op_type = 2'd0; s_found = 1'b1; s_index = 3'd3;
    step();
    op_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstprobe_ready", {op_ready, idx_we, op_done}, 3'b100);
    chk("rstprobe_random", random, 7);
    step();
    chk("rstprobe_no_idx", {idx_we, op_done, idx_p}, 0);

    // Back-to-back requests with op_valid held high
    op_valid = 1'b1; op_type = 2'd1; cp0_index = 3'd2; r_pfn0 = 20'h13579; r_g = 0; r_mask = 16'h00FF;
    chk("b2b_ready_T", op_ready, 1);
    step();
    chk("b2b_ready_T1", op_ready, 0);
    step();
    chk("b2b_T2", {op_ready, op_done, entry_we}, 3'b011);
    chk("b2b_e_pfn0", e_pfn0, 20'h13579);
    step();
    chk("b2b_ready_T3", {op_ready, op_done}, 2'b10);
    r_pfn0 = 20'h2468A;
    step();
    op_valid = 1'b0;
    chk("b2b_second_busy", {op_ready, entry_we}, 2'b00);
    step();
    chk("b2b_second_done", {op_done, entry_we}, 2'b11);
    chk("b2b_second_pfn0", e_pfn0, 20'h2468A);
    step();
    chk("b2b_final_idle", {op_ready, op_done}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
